// File: rtl/ex_stage_module.sv
// Execute stage: operand forwarding, ALU with NZCV flags, branch target adder,
// and the EX/MEM pipeline register.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   freeze                     downstream stall; holds every register
//   flush                      turns the captured instruction into a bubble
//   wb_en_in .. branch_in      control bits from ID
//   exe_cmd                    ALU operation
//   val_Rn, val_Rm, val2       operand 1, store data, operand 2
//   pc_in, imm24               PC+4 and signed word offset for branch target
//   dest_in                    destination register
//   sel_src1, sel_src2         forwarding selects for val_Rn / val_Rm
//   mem_fwd_val, wb_fwd_val    forwarded values from MEM / WB
//   *_out, status_out          registered results to MEM
//   branch_taken, branch_address, wb_en_hazard_in, dest_hazard_in
//                              combinational outputs, unaffected by freeze
module ex_stage_module #(
  parameter int unsigned REGISTER_LEN    = 32,
  parameter int unsigned REG_ADDRESS_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       flush,
  input  logic                       wb_en_in,
  input  logic                       mem_r_en_in,
  input  logic                       mem_w_en_in,
  input  logic                       s_en,
  input  logic                       branch_in,
  input  logic [3:0]                 exe_cmd,
  input  logic [REGISTER_LEN-1:0]    val_Rn,
  input  logic [REGISTER_LEN-1:0]    val_Rm,
  input  logic [REGISTER_LEN-1:0]    val2,
  input  logic [REGISTER_LEN-1:0]    pc_in,
  input  logic [23:0]                imm24,
  input  logic [REG_ADDRESS_LEN-1:0] dest_in,
  input  logic [1:0]                 sel_src1,
  input  logic [1:0]                 sel_src2,
  input  logic [REGISTER_LEN-1:0]    mem_fwd_val,
  input  logic [REGISTER_LEN-1:0]    wb_fwd_val,
  output logic                       wb_en_out,
  output logic                       mem_r_en_out,
  output logic                       mem_w_en_out,
  output logic [REGISTER_LEN-1:0]    alu_res_out,
  output logic [REGISTER_LEN-1:0]    val_Rm_out,
  output logic [REG_ADDRESS_LEN-1:0] dest_out,
  output logic [3:0]                 status_out,
  output logic                       branch_taken,
  output logic [REGISTER_LEN-1:0]    branch_address,
  output logic                       wb_en_hazard_in,
  output logic [REG_ADDRESS_LEN-1:0] dest_hazard_in
);

  localparam int unsigned W = REGISTER_LEN;

  logic [W-1:0] op_a, op_b, store_data;
  logic [W-1:0] alu_res;
  logic [W:0]   wide;
  logic [3:0]   flags;
  logic         carry_in, flag_c, flag_v;
  logic [W-1:0] imm_ext;

  // Forwarding muxes; select 11 falls back to the register-file value.
  always_comb begin
    op_a = val_Rn;
    unique case (sel_src1)
      2'b01:   op_a = mem_fwd_val;
      2'b10:   op_a = wb_fwd_val;
      default: op_a = val_Rn;
    endcase
    store_data = val_Rm;
    unique case (sel_src2)
      2'b01:   store_data = mem_fwd_val;
      2'b10:   store_data = wb_fwd_val;
      default: store_data = val_Rm;
    endcase
  end

  assign op_b     = val2;
  assign carry_in = status_out[1];

  // ALU. Arithmetic runs one bit wide so the top bit is carry (add) or
  // borrow (sub); C for subtraction is the inverted borrow.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    flag_c  = status_out[1];
    flag_v  = status_out[0];
    case (exe_cmd)
      4'b0001: alu_res = op_b;
      4'b1001: alu_res = ~op_b;
      4'b0010, 4'b0011: begin
        wide = {1'b0, op_a} + {1'b0, op_b};
        if (exe_cmd == 4'b0011) wide = wide + {{W{1'b0}}, carry_in};
        alu_res = wide[W-1:0];
        flag_c  = wide[W];
        flag_v  = (op_a[W-1] == op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
      end
      4'b0100, 4'b0101: begin
        wide = {1'b0, op_a} - {1'b0, op_b};
        if (exe_cmd == 4'b0101) wide = wide - {{W{1'b0}}, ~carry_in};
        alu_res = wide[W-1:0];
        flag_c  = ~wide[W];
        flag_v  = (op_a[W-1] != op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
      end
      4'b0110: alu_res = op_a & op_b;
      4'b0111: alu_res = op_a | op_b;
      4'b1000: alu_res = op_a ^ op_b;
      default: alu_res = '0;
    endcase
    flags = {alu_res[W-1], (alu_res == '0), flag_c, flag_v};
  end

  // Branch target: PC+4 plus sign-extended word offset.
  assign imm_ext        = {{(W - 24){imm24[23]}}, imm24};
  assign branch_address = pc_in + (imm_ext << 2);
  assign branch_taken   = branch_in;

  assign wb_en_hazard_in = wb_en_in;
  assign dest_hazard_in  = dest_in;

  // EX/MEM register. Flush zeroes the stage but leaves the flags alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      alu_res_out  <= '0;
      val_Rm_out   <= '0;
      dest_out     <= '0;
      status_out   <= '0;
    end else if (!freeze) begin
      if (flush) begin
        wb_en_out    <= 1'b0;
        mem_r_en_out <= 1'b0;
        mem_w_en_out <= 1'b0;
        alu_res_out  <= '0;
        val_Rm_out   <= '0;
        dest_out     <= '0;
      end else begin
        wb_en_out    <= wb_en_in;
        mem_r_en_out <= mem_r_en_in;
        mem_w_en_out <= mem_w_en_in;
        alu_res_out  <= alu_res;
        val_Rm_out   <= store_data;
        dest_out     <= dest_in;
        if (s_en) status_out <= flags;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_module.sv
module tb_ex_stage_module;

  logic        clk = 1'b0;
  logic        rst, freeze, flush;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_en, branch_in;
  logic [3:0]  exe_cmd;
  logic [31:0] val_Rn, val_Rm, val2, pc_in;
  logic [23:0] imm24;
  logic [3:0]  dest_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_fwd_val, wb_fwd_val;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_res_out, val_Rm_out;
  logic [3:0]  dest_out, status_out;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        wb_en_hazard_in;
  logic [3:0]  dest_hazard_in;

  ex_stage_module #(.REGISTER_LEN(32), .REG_ADDRESS_LEN(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_en(s_en), .branch_in(branch_in), .exe_cmd(exe_cmd),
    .val_Rn(val_Rn), .val_Rm(val_Rm), .val2(val2), .pc_in(pc_in), .imm24(imm24),
    .dest_in(dest_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .alu_res_out(alu_res_out), .val_Rm_out(val_Rm_out), .dest_out(dest_out),
    .status_out(status_out), .branch_taken(branch_taken),
    .branch_address(branch_address), .wb_en_hazard_in(wb_en_hazard_in),
    .dest_hazard_in(dest_hazard_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb, mr, mw;
    logic [31:0] alu, rm;
    logic [3:0]  dest, status;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   st;
  int     n_tests = 0;
  int     n_fail  = 0;

  localparam longint MaxS = 64'sh7FFF_FFFF;
  localparam longint MinS = -64'sh8000_0000;

  // Reference ALU from plain integer arithmetic; flags = {N,Z,C,V}.
  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] st_in,
                                  output logic [31:0] res, output logic [3:0] fl);
    longint unsigned ua, ub, cin;
    longint sa, sb, s;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    cin = st_in[1];
    c = st_in[1]; v = st_in[0];
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2, 4'd3: begin
        if (cmd == 4'd2) cin = 0;
        res = a + b + cin[31:0];
        c = (ua + ub + cin) >= 64'h1_0000_0000;
        s = sa + sb + longint'(cin);
        v = (s > MaxS) || (s < MinS);
      end
      4'd4, 4'd5: begin
        cin = (cmd == 4'd4) ? 0 : 1 - cin;  // borrow
        res = a - b - cin[31:0];
        c = ua >= ub + cin;
        s = sa - sb - longint'(cin);
        v = (s > MaxS) || (s < MinS);
      end
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: res = 32'd0;
    endcase
    fl = {res[31], res == 32'd0, c, v};
  endfunction

  task automatic clear_inputs();
    rst = 0; freeze = 0; flush = 0;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; s_en = 0; branch_in = 0;
    exe_cmd = 0; val_Rn = 0; val_Rm = 0; val2 = 0; pc_in = 0; imm24 = 0;
    dest_in = 0; sel_src1 = 0; sel_src2 = 0; mem_fwd_val = 0; wb_fwd_val = 0;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  task automatic random_inputs();
    rst = ($urandom_range(0, 39) == 0);
    freeze = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 5) == 0);
    wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
    s_en = 1'($urandom); branch_in = 1'($urandom);
    exe_cmd = 4'($urandom); val_Rn = pick32(); val_Rm = $urandom; val2 = pick32();
    pc_in = $urandom; imm24 = 24'($urandom); dest_in = 4'($urandom);
    sel_src1 = 2'($urandom); sel_src2 = 2'($urandom);
    mem_fwd_val = pick32(); wb_fwd_val = pick32();
  endtask

  // Called at posedge+1 with inputs set: predicts the state after the next
  // edge, queues it, checks the combinational outputs, then advances.
  task automatic do_cycle();
    logic [31:0] a, m, res;
    logic [3:0]  fl;
    logic [31:0] exp_ba;
    a = (sel_src1 == 2'd1) ? mem_fwd_val : (sel_src1 == 2'd2) ? wb_fwd_val : val_Rn;
    m = (sel_src2 == 2'd1) ? mem_fwd_val : (sel_src2 == 2'd2) ? wb_fwd_val : val_Rm;
    ref_alu(exe_cmd, a, val2, st.status, res, fl);
    if (rst) st = '0;
    else if (freeze) st = st;
    else if (flush) st = '{wb: 0, mr: 0, mw: 0, alu: 0, rm: 0, dest: 0, status: st.status};
    else st = '{wb: wb_en_in, mr: mem_r_en_in, mw: mem_w_en_in, alu: res, rm: m,
                dest: dest_in, status: s_en ? fl : st.status};
    sb_q.push_back(st);
    #1;
    exp_ba = 32'(longint'(pc_in) + longint'($signed(imm24)) * 4);
    n_tests++;
    if (branch_address !== exp_ba) begin
      n_fail++;
      $display("FAIL branch_address: got %h expected %h", branch_address, exp_ba);
    end
    n_tests++;
    if ({branch_taken, wb_en_hazard_in, dest_hazard_in} !== {branch_in, wb_en_in, dest_in}) begin
      n_fail++;
      $display("FAIL comb_copies: got %b/%b/%h expected %b/%b/%h", branch_taken,
               wb_en_hazard_in, dest_hazard_in, branch_in, wb_en_in, dest_in);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: registered outputs are stable at posedge+3; one expectation per edge.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk); #3;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        got = '{wb: wb_en_out, mr: mem_r_en_out, mw: mem_w_en_out, alu: alu_res_out,
                rm: val_Rm_out, dest: dest_out, status: status_out};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL ex_mem_reg @%0t: got wb%b mr%b mw%b alu=%h rm=%h d=%h st=%b expected wb%b mr%b mw%b alu=%h rm=%h d=%h st=%b",
                   $time, got.wb, got.mr, got.mw, got.alu, got.rm, got.dest, got.status,
                   e.wb, e.mr, e.mw, e.alu, e.rm, e.dest, e.status);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    st = '0;
    clear_inputs();
    rst = 1;
    do_cycle(); do_cycle();
    // ADD 5+7
    clear_inputs(); val_Rn = 5; val2 = 7; exe_cmd = 4'b0010; s_en = 1; wb_en_in = 1;
    dest_in = 3; do_cycle();
    // SUB 9-9, then ADC 1+1 with C=1
    val_Rn = 9; val2 = 9; exe_cmd = 4'b0100; do_cycle();
    val_Rn = 1; val2 = 1; exe_cmd = 4'b0011; do_cycle();
    // signed overflow
    val_Rn = 32'h7FFF_FFFF; val2 = 1; exe_cmd = 4'b0010; do_cycle();
    // forwarding
    clear_inputs(); sel_src1 = 2'b01; mem_fwd_val = 100; val_Rn = 1; val2 = 1;
    exe_cmd = 4'b0010; sel_src2 = 2'b10; wb_fwd_val = 32'hAB; val_Rm = 5;
    mem_w_en_in = 1; wb_en_in = 1; mem_r_en_in = 1; dest_in = 9; do_cycle();
    // freeze with flush for three cycles, then flush alone
    repeat (3) begin
      random_inputs(); rst = 0; freeze = 1; flush = 1; do_cycle();
    end
    random_inputs(); rst = 0; freeze = 0; flush = 1; do_cycle();
    // branch target and reset during a stall
    clear_inputs(); pc_in = 32'h100; imm24 = 24'hFF_FFFF; branch_in = 1; wb_en_in = 1;
    val2 = 3; exe_cmd = 4'b0001; dest_in = 2; do_cycle();
    freeze = 1; rst = 1; do_cycle();
    rst = 0; do_cycle();
    freeze = 0; do_cycle();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      random_inputs(); do_cycle();
    end
    #5;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
